ad9866_spi_ctrl: RTL and testbench

Sequences configuration of the AD9866 codec over its 3-wire SPI port. After reset it pulses the codec hardware reset and writes a fixed initialisation table. It then arbitrates run-time register writes between the RX gain path and a generic command requester. It sits between the control/command decoder of hermes_lite_core and the `ad9866_sclk/sdio/sen_n/rst_n` pins.

---
 rtl/ad9866_pkg.sv | 39 +++
 rtl/ad9866_spi_ctrl_if.sv | 22 ++
 rtl/ad9866_spi_shift.sv | 102 ++++++++++
 rtl/ad9866_spi_ctrl.sv | 149 ++++++++++++++
 tb/tb_ad9866_spi_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ad9866_pkg.sv
// ad9866_pkg
//   Shared types and constants for the AD9866 SPI configuration controller:
//   controller state encoding, SPI frame field widths, the codec bring-up
//   register table (init_entry) and the 16-bit write-frame builder.
package ad9866_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_INIT_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_IDLE
    } state_e;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int GAIN_W   = 6;
    localparam int FRAME_W  = 16;
    localparam int AD_W     = ADDR_W + DATA_W;
    localparam int INIT_LEN = 4;
    localparam int IDX_W    = 2;

    // Bring-up table, returned as {addr, data}.
    function automatic logic [AD_W-1:0] init_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    init_entry = {5'h01, 8'h20};
            2'd1:    init_entry = {5'h06, 8'h00};
            2'd2:    init_entry = {5'h07, 8'h3F};
            default: init_entry = {5'h09, 8'h40};
        endcase
    endfunction

    // Write frame: R/W=0, N1N0=00 (single byte), then address and data.
    function automatic logic [FRAME_W-1:0] write_frame(input logic [AD_W-1:0] ad);
        write_frame = {1'b0, 2'b00, ad};
    endfunction

endpackage

// File: rtl/ad9866_spi_ctrl_if.sv
// ad9866_spi_ctrl_if
//   Run-time write request bus into the AD9866 controller.
//   gain_req/gain_val/gain_ack : RX PGA gain write (level request, 1-cycle ack)
//   cmd_req/cmd_addr/cmd_data/cmd_ack : generic register write
//   master = requester side, slave = controller side.
interface ad9866_spi_ctrl_if;
    import ad9866_pkg::*;

    logic              gain_req;
    logic [GAIN_W-1:0] gain_val;
    logic              gain_ack;
    logic              cmd_req;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ack;

    modport master (output gain_req, gain_val, cmd_req, cmd_addr, cmd_data,
                    input  gain_ack, cmd_ack);
    modport slave  (input  gain_req, gain_val, cmd_req, cmd_addr, cmd_data,
                    output gain_ack, cmd_ack);

endinterface

// File: rtl/ad9866_spi_shift.sv
// ad9866_spi_shift
//   Serialises one 16-bit frame MSB first on the AD9866 3-wire port.
//   clk/rst_n : block clock, async active-low reset
//   start     : 1-cycle pulse, loads frame and drops sen_n on the next edge
//   frame     : word to send
//   done      : 1-cycle pulse in the cycle sen_n returns high
//   sclk/sdio/sen_n : SPI pins (sclk idles low, sdio changes on falling sclk)
module ad9866_spi_shift
    import ad9866_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic               sclk,
    output logic               sdio,
    output logic               sen_n
);
    localparam int DIV_W = $clog2(SCLK_DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         half_q, half_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               active_q, active_d;
    logic               sclk_q, sclk_d;
    logic               sdio_q, sdio_d;
    logic               sen_n_q, sen_n_d;
    logic               done_q, done_d;

    always_comb begin
        div_d    = div_q;
        half_d   = half_q;
        sh_d     = sh_q;
        active_d = active_q;
        sclk_d   = sclk_q;
        sdio_d   = sdio_q;
        sen_n_d  = sen_n_q;
        done_d   = 1'b0;
        if (start) begin
            active_d = 1'b1;
            sen_n_d  = 1'b0;
            sclk_d   = 1'b0;
            div_d    = '0;
            half_d   = '0;
            sdio_d   = frame[FRAME_W-1];
            sh_d     = {frame[FRAME_W-2:0], 1'b0};
        end else if (active_q) begin
            if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                div_d  = '0;
                half_d = half_q + 5'd1;
                // The 32nd half-period boundary is the last falling edge:
                // it also closes the frame.
                if (half_q == 5'd31) begin
                    active_d = 1'b0;
                    sen_n_d  = 1'b1;
                    sclk_d   = 1'b0;
                    sdio_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        sdio_d = sh_q[FRAME_W-1];
                        sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            half_q   <= '0;
            sh_q     <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdio_q   <= 1'b0;
            sen_n_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            half_q   <= half_d;
            sh_q     <= sh_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            sdio_q   <= sdio_d;
            sen_n_q  <= sen_n_d;
            done_q   <= done_d;
        end
    end

    assign done  = done_q;
    assign sclk  = sclk_q;
    assign sdio  = sdio_q;
    assign sen_n = sen_n_q;

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// ad9866_spi_ctrl
//   AD9866 configuration sequencer: pulses the codec reset, writes the
//   bring-up table, then serves run-time gain / generic register writes
//   (gain has priority).
//   ad9866spiclk, extreset_n : clock, async active-low reset
//   req_if (slave)           : gain and command write requests / acks
//   busy, init_done          : status (busy low only in IDLE; init_done sticky)
//   ad9866_sclk/sdio/sen_n   : 3-wire SPI pins
//   ad9866_rst_n             : codec hardware reset
module ad9866_spi_ctrl
    import ad9866_pkg::*;
#(
    parameter int              SCLK_DIV   = 4,
    parameter int              RST_CYCLES = 64,
    parameter int              RST_WAIT   = 256,
    parameter logic [ADDR_W-1:0] GAIN_ADDR = 5'h09
) (
    input  logic             ad9866spiclk,
    input  logic             extreset_n,
    ad9866_spi_ctrl_if.slave req_if,
    output logic             busy,
    output logic             init_done,
    output logic             ad9866_sclk,
    output logic             ad9866_sdio,
    output logic             ad9866_sen_n,
    output logic             ad9866_rst_n
);
    // GAP lasts 2*SCLK_DIV-2 cycles; together with the SHIFT->GAP cycle and
    // the frame-loading cycle this keeps sen_n high exactly 2*SCLK_DIV cycles
    // between init frames.
    localparam int GAP_LAST = 2 * SCLK_DIV - 3;
    localparam int CNT_MAX0 = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
    localparam int CNT_MAX  = (CNT_MAX0 > 2 * SCLK_DIV) ? CNT_MAX0 : 2 * SCLK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [FRAME_W-1:0] frame_q;
    logic               start_q;
    logic               gain_ack_q;
    logic               cmd_ack_q;
    logic               busy_q;
    logic               init_done_q;
    logic               codec_rst_n_q;
    logic               shift_done;

    always_ff @(posedge ad9866spiclk or negedge extreset_n) begin
        if (!extreset_n) begin
            state_q       <= ST_RST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_q       <= '0;
            start_q       <= 1'b0;
            gain_ack_q    <= 1'b0;
            cmd_ack_q     <= 1'b0;
            busy_q        <= 1'b1;
            init_done_q   <= 1'b0;
            codec_rst_n_q <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            gain_ack_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            case (state_q)
                ST_RST_HOLD: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_q       <= ST_RST_WAIT;
                        cnt_q         <= '0;
                        codec_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Exit one cycle early: the load cycle itself completes the wait.
                ST_RST_WAIT: begin
                    if (cnt_q == CNT_W'(RST_WAIT - 2)) begin
                        state_q <= ST_INIT_LOAD;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        frame_q <= write_frame(init_entry('0));
                        start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_INIT_LOAD: state_q <= ST_SHIFT;
                ST_SHIFT: begin
                    if (shift_done) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_LAST)) begin
                        cnt_q <= '0;
                        if (!init_done_q && idx_q != IDX_W'(INIT_LEN - 1)) begin
                            state_q <= ST_INIT_LOAD;
                            idx_q   <= idx_q + IDX_W'(1);
                            frame_q <= write_frame(init_entry(idx_q + IDX_W'(1)));
                            start_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            init_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_if.gain_req) begin
                        state_q    <= ST_SHIFT;
                        busy_q     <= 1'b1;
                        gain_ack_q <= 1'b1;
                        start_q    <= 1'b1;
                        frame_q    <= write_frame({GAIN_ADDR, 2'b01, req_if.gain_val});
                    end else if (req_if.cmd_req) begin
                        state_q   <= ST_SHIFT;
                        busy_q    <= 1'b1;
                        cmd_ack_q <= 1'b1;
                        start_q   <= 1'b1;
                        frame_q   <= write_frame({req_if.cmd_addr, req_if.cmd_data});
                    end
                end
                default: state_q <= ST_RST_HOLD;
            endcase
        end
    end

    ad9866_spi_shift #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shift (
        .clk   (ad9866spiclk),
        .rst_n (extreset_n),
        .start (start_q),
        .frame (frame_q),
        .done  (shift_done),
        .sclk  (ad9866_sclk),
        .sdio  (ad9866_sdio),
        .sen_n (ad9866_sen_n)
    );

    assign req_if.gain_ack = gain_ack_q;
    assign req_if.cmd_ack  = cmd_ack_q;
    assign busy            = busy_q;
    assign init_done       = init_done_q;
    assign ad9866_rst_n    = codec_rst_n_q;

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// tb_ad9866_spi_ctrl
//   Directed bench for ad9866_spi_ctrl (SCLK_DIV=4, RST_CYCLES=64,
//   RST_WAIT=256): reset values, init sequence timing and contents, run-time
//   command and gain writes, arbitration, reset abort, SPI protocol monitor.
module tb_ad9866_spi_ctrl;

    logic clk = 1'b0;
    logic extreset_n;
    logic busy, init_done, sclk, sdio, sen_n, codec_rst_n;

    ad9866_spi_ctrl_if bus ();

    ad9866_spi_ctrl #(
        .SCLK_DIV  (4),
        .RST_CYCLES(64),
        .RST_WAIT  (256),
        .GAIN_ADDR (5'h09)
    ) dut (
        .ad9866spiclk(clk),
        .extreset_n  (extreset_n),
        .req_if      (bus),
        .busy        (busy),
        .init_done   (init_done),
        .ad9866_sclk (sclk),
        .ad9866_sdio (sdio),
        .ad9866_sen_n(sen_n),
        .ad9866_rst_n(codec_rst_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] init_words [4] = '{16'h0120, 16'h0600, 16'h073F, 16'h0940};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI monitor: captures frames on rising sclk and checks the protocol.
    logic        prev_sen   = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        prev_sdio  = 1'b0;
    logic        mon_active = 1'b0;
    logic [15:0] mon_word   = '0;
    logic [15:0] last_word  = '0;
    int          mon_cnt    = 0;
    int          frame_cnt  = 0;
    int          last_fall  = 0;
    int          last_rise  = -1;
    int          early_ack  = 0;

    always @(posedge clk) begin
        #1;
        if (!extreset_n) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
            last_rise  = -1;
            prev_sen   = 1'b1;
            prev_sclk  = 1'b0;
            prev_sdio  = 1'b0;
        end else begin
            if (prev_sclk && sclk) chk("sdio_stable_sclk_high", 32'(sdio), 32'(prev_sdio));
            if (prev_sen && !sen_n) begin
                if (last_rise >= 0) chk("gap_ge_8", 32'(cyc - last_rise >= 8), 1);
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_word   = '0;
                last_fall  = cyc;
            end
            if (mon_active && !prev_sclk && sclk) begin
                mon_word = {mon_word[14:0], sdio};
                mon_cnt++;
            end
            if (mon_active && !prev_sen && sen_n) begin
                chk("rising_edges_per_frame", mon_cnt, 16);
                last_word  = mon_word;
                last_rise  = cyc;
                mon_active = 1'b0;
                frame_cnt++;
            end
            if (bus.cmd_ack && !init_done) early_ack++;
            prev_sen  = sen_n;
            prev_sclk = sclk;
            prev_sdio = sdio;
        end
    end

    task automatic wait_frame(input int fc);
        int t = 0;
        while (frame_cnt == fc && t < 400) begin @(negedge clk); t++; end
    endtask

    // Releases reset and checks the full reset pulse + init table sequence.
    task automatic run_init();
        int t, rel, rise, prev, fc;
        @(negedge clk);
        extreset_n = 1'b1;
        rel = cyc;
        t = 0;
        while (codec_rst_n !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        rise = cyc;
        chk("codec_rst_low_cycles", rise - rel, 64);
        t = 0;
        while (sen_n !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
        chk("first_frame_after_rst", cyc - rise, 256);
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            fc = frame_cnt;
            wait_frame(fc);
            chk("init_frame_word", 32'(last_word), 32'(init_words[i]));
            if (i > 0) chk("init_frame_period", last_fall - prev, 136);
            chk("init_done_still_low", 32'(init_done), 0);
            prev = last_fall;
        end
        t = 0;
        while (init_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("init_done_after_last_gap", cyc - last_fall, 135);
        chk("busy_low_first_idle", 32'(busy), 0);
    endtask

    initial begin
        int t, a, ga, fc;
        extreset_n    = 1'b0;
        bus.gain_req  = 1'b0;
        bus.gain_val  = '0;
        bus.cmd_req   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);

        chk("rst_codec_rst_n", 32'(codec_rst_n), 0);
        chk("rst_sen_n",       32'(sen_n), 1);
        chk("rst_sclk",        32'(sclk), 0);
        chk("rst_sdio",        32'(sdio), 0);
        chk("rst_busy",        32'(busy), 1);
        chk("rst_init_done",   32'(init_done), 0);
        chk("rst_gain_ack",    32'(bus.gain_ack), 0);
        chk("rst_cmd_ack",     32'(bus.cmd_ack), 0);

        // Command held high throughout init: must wait for the first IDLE.
        bus.cmd_req  = 1'b1;
        bus.cmd_addr = 5'h04;
        bus.cmd_data = 8'hA5;
        run_init();
        chk("no_cmd_ack_during_init", early_ack, 0);
        @(negedge clk);
        chk("cmd_ack_after_first_idle", 32'(bus.cmd_ack), 1);
        bus.cmd_req = 1'b0;
        a  = cyc;
        fc = frame_cnt;
        @(negedge clk);
        chk("cmd_ack_one_cycle", 32'(bus.cmd_ack), 0);
        chk("busy_during_frame", 32'(busy), 1);
        wait_frame(fc);
        chk("cmd_frame_word", 32'(last_word), 32'h04A5);
        chk("ack_to_sen_n_latency", last_fall - a, 1);

        // Gain and command together: gain wins, command follows one frame later.
        t = 0;
        while (busy !== 1'b0 && t < 300) begin @(negedge clk); t++; end
        bus.gain_req = 1'b1;
        bus.gain_val = 6'h2A;
        bus.cmd_req  = 1'b1;
        bus.cmd_addr = 5'h1F;
        bus.cmd_data = 8'hFF;
        t = 0;
        while (bus.gain_ack !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        chk("gain_ack_seen", 32'(bus.gain_ack), 1);
        chk("cmd_ack_not_with_gain", 32'(bus.cmd_ack), 0);
        bus.gain_req = 1'b0;
        ga = cyc;
        fc = frame_cnt;
        wait_frame(fc);
        chk("gain_frame_word", 32'(last_word), 32'h096A);
        fc = frame_cnt;
        t = 0;
        while (bus.cmd_ack !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        chk("cmd_ack_after_gain", cyc - ga, 137);
        bus.cmd_req = 1'b0;
        wait_frame(fc);
        chk("max_cmd_frame_word", 32'(last_word), 32'h1FFF);

        // Reset in the middle of a frame, while bit 7 is on the wire.
        t = 0;
        while (busy !== 1'b0 && t < 300) begin @(negedge clk); t++; end
        bus.cmd_req  = 1'b1;
        bus.cmd_addr = 5'h12;
        bus.cmd_data = 8'h34;
        t = 0;
        while (bus.cmd_ack !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        bus.cmd_req = 1'b0;
        t = 0;
        while (mon_cnt != 9 && t < 300) begin @(negedge clk); t++; end
        chk("abort_point_reached", mon_cnt, 9);
        extreset_n = 1'b0;
        #1;
        chk("abort_sen_n", 32'(sen_n), 1);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_codec_rst_n", 32'(codec_rst_n), 0);
        chk("abort_busy", 32'(busy), 1);
        chk("abort_init_done", 32'(init_done), 0);
        repeat (5) @(negedge clk);
        run_init();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
